// File: rtl/uart_rx_fsm.sv
`default_nettype none
// uart_rx_fsm: UART receive frame controller that sequences start, data, parity and stop bits.
// Rev 1.0: initial release.
module uart_rx_fsm #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6,
    parameter int BITC_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [BITC_W-1:0]  bit_cnt,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               cnt_en,
    output logic               samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   par_lat;
    logic   par_lat_nxt;
    logic   frame_err_nxt;
    logic   edge_last;
    logic   data_last;

    // cnt_en is high in every state that consults edge_last, so edge_last alone is bit_end there.
    assign edge_last = (edge_cnt == (prescale - PRESC_W'(1)));
    assign data_last = (bit_cnt == BITC_W'(DATA_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            par_lat   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            par_lat   <= par_lat_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        par_lat_nxt   = par_lat;
        frame_err_nxt = 1'b0;
        cnt_en        = 1'b0;
        samp_en       = 1'b0;
        deser_en      = 1'b0;
        strt_chk_en   = 1'b0;
        par_chk_en    = 1'b0;
        stp_chk_en    = 1'b0;
        data_valid    = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_in) begin
                    state_nxt   = START;
                    par_lat_nxt = par_en;
                end
            end
            START: begin
                cnt_en      = 1'b1;
                samp_en     = 1'b1;
                strt_chk_en = 1'b1;
                if (edge_last) begin
                    if (strt_glitch) begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                cnt_en   = 1'b1;
                samp_en  = 1'b1;
                deser_en = 1'b1;
                if (edge_last && data_last) begin
                    state_nxt = par_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_en     = 1'b1;
                samp_en    = 1'b1;
                par_chk_en = 1'b1;
                if (edge_last) begin
                    if (par_err) begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                    end else begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                cnt_en     = 1'b1;
                samp_en    = 1'b1;
                stp_chk_en = 1'b1;
                if (edge_last) begin
                    if (stp_err) begin
                        state_nxt     = IDLE;
                        frame_err_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // cnt_en stays low here so the counter clears between back-to-back frames.
                data_valid = 1'b1;
                if (!rx_in) begin
                    state_nxt   = START;
                    par_lat_nxt = par_en;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// tb_uart_rx_fsm: directed self-checking bench for uart_rx_fsm with a behavioural edge/bit counter.
module tb_uart_rx_fsm;

    localparam int DATA_W  = 8;
    localparam int PRESC_W = 6;
    localparam int BITC_W  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               rx_in;
    logic               par_en;
    logic [PRESC_W-1:0] prescale;
    logic [BITC_W-1:0]  bit_cnt;
    logic [PRESC_W-1:0] edge_cnt;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;
    logic               cnt_en;
    logic               samp_en;
    logic               deser_en;
    logic               strt_chk_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               data_valid;
    logic               frame_err;

    uart_rx_fsm #(.DATA_W(DATA_W), .PRESC_W(PRESC_W), .BITC_W(BITC_W)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en), .samp_en(samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Edge/bit counter the FSM drives; clears whenever cnt_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale - PRESC_W'(1)) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BITC_W'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESC_W'(1);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_dv = 0, n_fe = 0, n_deser = 0, n_par = 0, n_stp = 0, n_both = 0;
    int   t_dv = -1, t_dv_prev = -1, t_fe = -1, t_deser_rise = -1, t_par_rise = -1, bit_par_rise = -1;
    logic deser_q = 1'b0, par_q = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid && frame_err) n_both++;
            if (data_valid) begin n_dv++; t_dv_prev = t_dv; t_dv = cyc; end
            if (frame_err) begin n_fe++; t_fe = cyc; end
            if (deser_en) n_deser++;
            if (stp_chk_en) n_stp++;
            if (par_chk_en) n_par++;
            if (deser_en && !deser_q) t_deser_rise = cyc;
            if (par_chk_en && !par_q) begin t_par_rise = cyc; bit_par_rise = int'(bit_cnt); end
        end
        deser_q = deser_en;
        par_q   = par_chk_en;
    end

    int total = 0;
    int bad   = 0;
    int b_dv, b_fe, b_deser, b_par, b_stp;
    int s0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_dv = n_dv; b_fe = n_fe; b_deser = n_deser; b_par = n_par; b_stp = n_stp;
    endtask

    task automatic line(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // Called right after a negedge; s0 becomes the cycle in which START is first seen.
    task automatic send_frame(input logic [7:0] d, input bit with_par);
        int p;
        p  = int'(prescale);
        s0 = cyc + 1;
        line(1'b0, p);
        for (int i = 0; i < 8; i++) line(d[i], p);
        if (with_par) line(^d, p);
        line(1'b1, p);
    endtask

    task automatic start_only();
        s0 = cyc + 1;
        line(1'b0, int'(prescale));
        line(1'b1, 200);
    endtask

    function automatic logic [7:0] outs();
        return {cnt_en, samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outs", 32'(outs()), 32'd0);

        // Frame 0xA5, prescale 8, no parity
        snap();
        send_frame(8'hA5, 1'b0);
        repeat (10) @(negedge clk);
        check("t1_data_entry", t_deser_rise, s0 + 8);
        check("t1_dv_time", t_dv, s0 + 80);
        check("t1_dv_count", n_dv - b_dv, 1);
        check("t1_fe_count", n_fe - b_fe, 0);
        check("t1_deser_cycles", n_deser - b_deser, 64);

        // Frame 0x3C, prescale 16, even parity
        prescale = 6'd16; par_en = 1'b1;
        snap();
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check("t2_par_entry", t_par_rise, s0 + 144);
        check("t2_par_bitcnt", bit_par_rise, 9);
        check("t2_par_cycles", n_par - b_par, 16);
        check("t2_dv_time", t_dv, s0 + 176);
        check("t2_fe_count", n_fe - b_fe, 0);

        // Start glitch
        prescale = 6'd8; par_en = 1'b0; strt_glitch = 1'b1;
        snap();
        start_only();
        check("t3_fe_count", n_fe - b_fe, 1);
        check("t3_fe_time", t_fe, s0 + 8);
        check("t3_deser_cycles", n_deser - b_deser, 0);
        check("t3_dv_count", n_dv - b_dv, 0);
        check("t3_idle_outs", 32'(outs()), 32'd0);
        strt_glitch = 1'b0;

        // Parity error
        par_en = 1'b1; par_err = 1'b1;
        snap();
        start_only();
        check("t4a_fe_count", n_fe - b_fe, 1);
        check("t4a_fe_time", t_fe, s0 + 80);
        check("t4a_par_cycles", n_par - b_par, 8);
        check("t4a_stp_cycles", n_stp - b_stp, 0);
        check("t4a_dv_count", n_dv - b_dv, 0);
        par_err = 1'b0;

        // Stop error
        par_en = 1'b0; stp_err = 1'b1;
        snap();
        start_only();
        check("t4b_fe_count", n_fe - b_fe, 1);
        check("t4b_fe_time", t_fe, s0 + 80);
        check("t4b_stp_cycles", n_stp - b_stp, 8);
        check("t4b_dv_count", n_dv - b_dv, 0);
        check("t4b_idle_outs", 32'(outs()), 32'd0);
        stp_err = 1'b0;

        // Back-to-back frames; rx_in low during DONE, par_en flipped mid second frame
        snap();
        s0 = cyc + 1;
        line(1'b0, 8);
        for (int i = 0; i < 8; i++) line(1'(8'h5A >> i), 8);
        line(1'b1, 8);
        line(1'b0, 9);
        par_en = 1'b1;
        for (int i = 0; i < 8; i++) line(1'(8'h96 >> i), 8);
        line(1'b1, 8);
        repeat (10) @(negedge clk);
        check("t5_dv_count", n_dv - b_dv, 2);
        check("t5_dv1_time", t_dv_prev, s0 + 80);
        check("t5_dv2_time", t_dv, s0 + 161);
        check("t5_par_cycles", n_par - b_par, 0);
        check("t5_fe_count", n_fe - b_fe, 0);
        par_en = 1'b0;

        // Asynchronous reset in DATA at bit_cnt 4
        snap();
        line(1'b0, 8);
        rx_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (deser_en && bit_cnt == BITC_W'(4)) found = 1'b1;
            else @(negedge clk);
        end
        check("t6_reached_bit4", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1 check("t6_async_outs", 32'(outs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t6_idle_outs", 32'(outs()), 32'd0);
        check("t6_dv_count", n_dv - b_dv, 0);
        check("t6_fe_count", n_fe - b_fe, 0);

        check("never_dv_and_fe", n_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
